// File: rtl/edgegate_bank_if.sv
// Control/status bundle for edgegate_bank: per-channel mode/enable/start in, busy/done/clkout out.
// edge_count is carried only when EDGEGATE_BANK_COUNT_EN is defined.
interface edgegate_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]   en;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   start;
  logic [CNT_W-1:0]      burst_len;
  logic [CHANNELS-1:0]   busy;
  logic [CHANNELS-1:0]   done;
  logic [CHANNELS-1:0]   clkout;
`ifdef EDGEGATE_BANK_COUNT_EN
  logic [CHANNELS*CNT_W-1:0] edge_count;

  modport master (output en, mode, start, burst_len, input busy, done, clkout, edge_count);
  modport slave  (input en, mode, start, burst_len, output busy, done, clkout, edge_count);
`else
  modport master (output en, mode, start, burst_len, input busy, done, clkout);
  modport slave  (input en, mode, start, burst_len, output busy, done, clkout);
`endif
endinterface

// File: rtl/edgegate_bank.sv
// Multi-channel glitch-free clock gate with off / free-run / burst / step modes per channel.
// Optional per-channel passed-pulse counters are built when EDGEGATE_BANK_COUNT_EN is defined.
module edgegate_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  edgegate_bank_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b11;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           state_reg, state_next;
    logic             g_reg, g_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       run_mode_reg, run_mode_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             gate_l;
    logic [1:0]       mode_i;
    logic [CNT_W-1:0] req_len;

    assign mode_i  = bus.mode[2*gi +: 2];
    assign req_len = (mode_i == MODE_STEP) ? CNT_W'(1) : bus.burst_len;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg    <= IDLE;
        g_reg        <= 1'b0;
        cnt_reg      <= '0;
        run_mode_reg <= MODE_OFF;
        busy_reg     <= 1'b0;
        done_reg     <= 1'b0;
      end else begin
        state_reg    <= state_next;
        g_reg        <= g_next;
        cnt_reg      <= cnt_next;
        run_mode_reg <= run_mode_next;
        busy_reg     <= busy_next;
        done_reg     <= done_next;
      end
    end

    always_comb begin
      state_next    = state_reg;
      g_next        = g_reg;
      cnt_next      = cnt_reg;
      run_mode_next = run_mode_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;

      if (state_reg == BURST && mode_i != run_mode_reg) begin
        // Mode changed mid-burst: abort silently, no done pulse.
        g_next     = 1'b0;
        busy_next  = 1'b0;
        cnt_next   = '0;
        state_next = (mode_i == MODE_RUN) ? RUN : IDLE;
      end else begin
        case (mode_i)
          MODE_OFF: begin
            state_next = IDLE;
            g_next     = 1'b0;
            busy_next  = 1'b0;
          end
          MODE_RUN: begin
            state_next = RUN;
            g_next     = bus.en[gi];
            busy_next  = 1'b0;
          end
          default: begin
            if (state_reg == BURST && cnt_reg != CNT_W'(1)) begin
              cnt_next = cnt_reg - CNT_W'(1);
            end else begin
              // Last pulse edge (or not bursting): the channel is idle here,
              // so a start on this same edge chains with no gap cycle.
              done_next  = (state_reg == BURST);
              state_next = IDLE;
              g_next     = 1'b0;
              busy_next  = 1'b0;
              cnt_next   = '0;
              if (bus.start[gi]) begin
                if (req_len != '0) begin
                  state_next    = BURST;
                  cnt_next      = req_len;
                  g_next        = 1'b1;
                  busy_next     = 1'b1;
                  run_mode_next = mode_i;
                end else begin
                  done_next = 1'b1;
                end
              end
            end
          end
        endcase
      end
    end

    // Latch is transparent only while clk is low, so g changing after posedge never clips a pulse.
    always_latch begin
      if (!clk) gate_l <= g_reg;
    end

    assign bus.clkout[gi] = clk & gate_l;
    assign bus.busy[gi]   = busy_reg;
    assign bus.done[gi]   = done_reg;

`ifdef EDGEGATE_BANK_COUNT_EN
    logic [CNT_W-1:0] edge_cnt_reg;

    // g_reg at a posedge is exactly what the latch is passing during that high phase.
    always_ff @(posedge clk) begin
      if (rst) edge_cnt_reg <= '0;
      else if (g_reg) edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
    end

    assign bus.edge_count[CNT_W*gi +: CNT_W] = edge_cnt_reg;
`endif
  end
endmodule

// File: tb/tb_edgegate_bank.sv
// Directed bench for edgegate_bank: reset, burst, zero-length, step/free-run, abort, optional counter wrap.
module tb_edgegate_bank;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   edge_no = 0;

  edgegate_bank_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();
  edgegate_bank #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef EDGEGATE_BANK_COUNT_EN
  edgegate_bank_if #(.CHANNELS(1), .CNT_W(4)) bus4 ();
  edgegate_bank #(.CHANNELS(1), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Wait one posedge, sample inside the clk-high phase, compare all three outputs.
  task automatic edge_chk(input string tag, input logic [3:0] exp_clk,
                          input logic [3:0] exp_busy, input logic [3:0] exp_done);
    @(posedge clk); #2;
    edge_no++;
    $display("edge %0d %s: clkout=%b busy=%b done=%b", edge_no, tag, bus.clkout, bus.busy, bus.done);
    check({tag, " clkout"}, 32'(bus.clkout), 32'(exp_clk));
    check({tag, " busy"},   32'(bus.busy),   32'(exp_busy));
    check({tag, " done"},   32'(bus.done),   32'(exp_done));
  endtask

  initial begin
    rst           = 1'b1;
    bus.mode      = 8'b01010101;
    bus.en        = 4'hF;
    bus.start     = 4'h0;
    bus.burst_len = 8'd0;
`ifdef EDGEGATE_BANK_COUNT_EN
    bus4.mode      = 2'b01;
    bus4.en        = 1'b0;
    bus4.start     = 1'b0;
    bus4.burst_len = 4'd0;
`endif

    // Reset: two edges with free-run + en high, then pulses from the 2nd edge after release
    @(posedge clk); #2;
    edge_no++;
    $display("edge %0d rst1: busy=%b done=%b", edge_no, bus.busy, bus.done);
    check("rst1 busy", 32'(bus.busy), 32'd0);
    check("rst1 done", 32'(bus.done), 32'd0);
    edge_chk("rst2", 4'h0, 4'h0, 4'h0);
`ifdef EDGEGATE_BANK_COUNT_EN
    check("rst edge_count", 32'(bus4.edge_count), 32'd0);
`endif
    rst = 1'b0;
    edge_chk("rel1", 4'h0, 4'h0, 4'h0);
    edge_chk("rel2", 4'hF, 4'h0, 4'h0);
    bus.mode = 8'h00;
    edge_chk("off1", 4'hF, 4'h0, 4'h0);
    edge_chk("off2", 4'h0, 4'h0, 4'h0);

    // Burst of 5 on ch0; a start with another length mid-burst is ignored
    bus.mode      = 8'b00000010;
    bus.burst_len = 8'd5;
    bus.start     = 4'b0001;
    edge_chk("b_acc", 4'h0, 4'h1, 4'h0);
    bus.start = 4'h0;
    edge_chk("b_p1", 4'h1, 4'h1, 4'h0);
    bus.start     = 4'b0001;
    bus.burst_len = 8'd9;
    edge_chk("b_p2", 4'h1, 4'h1, 4'h0);
    bus.start     = 4'h0;
    bus.burst_len = 8'd5;
    edge_chk("b_p3", 4'h1, 4'h1, 4'h0);
    edge_chk("b_p4", 4'h1, 4'h1, 4'h0);
    edge_chk("b_p5", 4'h1, 4'h0, 4'h1);
    edge_chk("b_end", 4'h0, 4'h0, 4'h0);

    // Zero-length burst: done only
    bus.burst_len = 8'd0;
    bus.start     = 4'b0001;
    edge_chk("z_acc", 4'h0, 4'h0, 4'h1);
    bus.start = 4'h0;
    edge_chk("z_end", 4'h0, 4'h0, 4'h0);

    // ch1 step twice back-to-back, ch2 free-run with toggling en
    bus.mode  = 8'b00011100;
    bus.start = 4'b0010;
    bus.en    = 4'b0100;
    edge_chk("s0", 4'h0, 4'h2, 4'h0);
    bus.en = 4'b0000;
    edge_chk("s1", 4'h6, 4'h2, 4'h2);
    bus.start = 4'h0;
    bus.en    = 4'b0100;
    edge_chk("s2", 4'h2, 4'h0, 4'h2);
    bus.en = 4'b0000;
    edge_chk("s3", 4'h4, 4'h0, 4'h0);
    bus.en = 4'b0100;
    edge_chk("s4", 4'h0, 4'h0, 4'h0);
    bus.en = 4'b0000;
    edge_chk("s5", 4'h4, 4'h0, 4'h0);

    // Abort: burst of 20 cut to mode 00 on the 7th pulse edge
    bus.mode      = 8'b00000010;
    bus.burst_len = 8'd20;
    bus.start     = 4'b0001;
    edge_chk("a_acc", 4'h0, 4'h1, 4'h0);
    bus.start = 4'h0;
    for (int i = 0; i < 6; i++) edge_chk("a_run", 4'h1, 4'h1, 4'h0);
    bus.mode = 8'h00;
    edge_chk("a_cut", 4'h1, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) edge_chk("a_off", 4'h0, 4'h0, 4'h0);

`ifdef EDGEGATE_BANK_COUNT_EN
    // 18 free-run pulses on a 4-bit counter wrap to 2
    begin
      int pulses;
      pulses  = 0;
      bus4.en = 1'b1;
      for (int i = 0; i < 18; i++) begin
        @(posedge clk); #2;
        if (bus4.clkout[0]) pulses++;
      end
      bus4.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #2;
        if (bus4.clkout[0]) pulses++;
      end
      $display("count: pulses=%0d edge_count=%0d", pulses, bus4.edge_count);
      check("wrap pulses", 32'(pulses), 32'd18);
      check("wrap edge_count", 32'(bus4.edge_count), 32'd2);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
